booth_mac_acc: RTL and testbench

//  Downstream consumer of the 8x8 signed Booth multiplier. Accepts a stream of signed operand pairs over valid/ready.

---
 rtl/booth_mac_acc.sv | 178 +++++++++++++++++
 tb/tb_booth_mac_acc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_acc.sv
// Signed MAC stage: a radix-4 Booth 8x8 multiplier feeds a framed ACC_W-bit accumulator, with valid/ready on both sides.
// Optional macro SATURATE_EN clamps the accumulator on signed overflow; when it is undefined the accumulator wraps.

module booth_mul (
  input  logic signed [7:0]  a_i,
  input  logic signed [7:0]  b_i,
  output logic signed [15:0] prod_o
);

  logic [8:0]         bx;
  logic signed [15:0] aExt;
  logic signed [15:0] pp;
  logic signed [15:0] sum;

  // Each 3-bit window of {b, 0} selects one partial product: 0, +-a or +-2a.
  always_comb begin
    bx   = {b_i, 1'b0};
    aExt = 16'(a_i);
    sum  = '0;
    pp   = '0;
    for (int i = 0; i < 4; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp = aExt;
        3'b011:         pp = aExt <<< 1;
        3'b100:         pp = -(aExt <<< 1);
        3'b101, 3'b110: pp = -aExt;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2*i));
    end
    prod_o = sum;
  end

endmodule

module booth_mac_acc #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {ACCUM, WAIT, HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic               p1_valid_q;
  logic [7:0]         p1_a_q, p1_b_q;
  logic               p1_last_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               overflow_q, overflow_d;

  logic signed [15:0] prod;
  logic [ACC_W-1:0]   prodExt, sumRaw, accUpd;
  logic [CNT_W-1:0]   countUpd;
  logic               ovfNow, inXfer, outXfer, clearAct;

  booth_mul u_mul (
    .a_i    (p1_a_q),
    .b_i    (p1_b_q),
    .prod_o (prod)
  );

  assign in_ready = (state_q == ACCUM) && rst_n;
  assign inXfer   = in_valid && in_ready;
  assign outXfer  = out_valid_q && out_ready;
  assign clearAct = clear && (state_q == ACCUM);

  assign prodExt  = ACC_W'(prod);
  assign sumRaw   = acc_q + prodExt;
  assign ovfNow   = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sumRaw[ACC_W-1] != acc_q[ACC_W-1]);
  assign countUpd = (count_q == '1) ? count_q : count_q + CNT_W'(1);

`ifdef SATURATE_EN
  // Both operands share a sign on overflow, so the accumulator's sign picks the rail.
  assign accUpd = ovfNow ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sumRaw;
`else
  assign accUpd = sumRaw;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (inXfer && in_last) state_d = WAIT;
      WAIT:    state_d = HOLD;
      HOLD:    if (outXfer) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;
    if (outXfer) out_valid_d = 1'b0;
    // A clear drops whatever term sits in p1; a pair accepted alongside it starts the new frame.
    if (clearAct) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (p1_valid_q) begin
      if (p1_last_q) begin
        out_acc_d   = accUpd;
        out_count_d = countUpd;
        overflow_d  = ovf_q | ovfNow;
        out_valid_d = 1'b1;
        acc_d       = '0;
        count_d     = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d   = accUpd;
        count_d = countUpd;
        ovf_d   = ovf_q | ovfNow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      p1_valid_q  <= 1'b0;
      p1_a_q      <= '0;
      p1_b_q      <= '0;
      p1_last_q   <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_valid_q  <= inXfer;
      if (inXfer) begin
        p1_a_q    <= in_a;
        p1_b_q    <= in_b;
        p1_last_q <= in_last;
      end
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc with ACC_W=16 so the overflow boundary is easy to reach.
// The expected result of the overflow frame depends on whether SATURATE_EN is defined.

module tb_booth_mac_acc;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  logic                    clk;
  logic                    rstN;
  logic                    inValid;
  logic                    inReady;
  logic signed [7:0]       inA;
  logic signed [7:0]       inB;
  logic                    inLast;
  logic                    clearIn;
  logic                    outValid;
  logic                    outReady;
  logic signed [ACC_W-1:0] outAcc;
  logic [CNT_W-1:0]        outCount;
  logic                    overflowOut;

  int checks   = 0;
  int failures = 0;

  booth_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_a      (inA),
    .in_b      (inB),
    .in_last   (inLast),
    .clear     (clearIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_acc   (outAcc),
    .out_count (outCount),
    .overflow  (overflowOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one pair for exactly one clock edge, then returns 1ns after that edge.
  task automatic applyStimulus(input logic signed [7:0] a, input logic signed [7:0] b,
                               input logic last, input logic clr);
    inValid = 1'b1;
    inA     = a;
    inB     = b;
    inLast  = last;
    clearIn = clr;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    clearIn = 1'b0;
  endtask

  task automatic waitResult(input int limit);
    int n = 0;
    while (!outValid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("result_timeout", int'(outValid), 1);
  endtask

  task automatic checkResult(input string tag, input int acc, input int cnt, input int ovf);
    checkOutput({tag, "_acc"}, int'(outAcc), acc);
    checkOutput({tag, "_count"}, int'(outCount), cnt);
    checkOutput({tag, "_overflow"}, int'(overflowOut), ovf);
  endtask

  // Lets a waiting result drain with outReady high and confirms the port is free again.
  task automatic drainResult(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_drain_valid"}, int'(outValid), 0);
    checkOutput({tag, "_drain_ready"}, int'(inReady), 1);
  endtask

  initial begin
    int ovfExpected;
    rstN     = 1'b0;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    inLast   = 1'b0;
    clearIn  = 1'b0;
    outReady = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(inReady), 0);
    checkOutput("reset_out_valid", int'(outValid), 0);
    checkResult("reset", 0, 0, 0);
    rstN = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", int'(inReady), 1);

    // Single term with exact two-edge latency.
    applyStimulus(-8'sd3, 8'sd5, 1'b1, 1'b0);
    checkOutput("t1_valid_early", int'(outValid), 0);
    checkOutput("t1_in_ready_wait", int'(inReady), 0);
    @(posedge clk);
    #1;
    checkOutput("t1_valid_latency", int'(outValid), 1);
    checkResult("t1", -15, 1, 0);
    drainResult("t1");

    // Four back-to-back terms: 1 + 4 + 9 + 16.
    applyStimulus(8'sd1, 8'sd1, 1'b0, 1'b0);
    applyStimulus(8'sd2, 8'sd2, 1'b0, 1'b0);
    applyStimulus(8'sd3, 8'sd3, 1'b0, 1'b0);
    applyStimulus(8'sd4, 8'sd4, 1'b1, 1'b0);
    waitResult(5);
    checkResult("t2", 30, 4, 0);
    drainResult("t2");

    // Backpressure holds the result and blocks input.
    outReady = 1'b0;
    applyStimulus(8'sd10, -8'sd3, 1'b1, 1'b0);
    waitResult(5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t3_hold_valid", int'(outValid), 1);
      checkOutput("t3_hold_acc", int'(outAcc), -30);
      checkOutput("t3_hold_in_ready", int'(inReady), 0);
    end
    outReady = 1'b1;
    drainResult("t3");

    // 16384 + 16384 crosses the 16-bit signed limit.
`ifdef SATURATE_EN
    ovfExpected = 32767;
`else
    ovfExpected = -32768;
`endif
    applyStimulus(-8'sd128, -8'sd128, 1'b0, 1'b0);
    applyStimulus(-8'sd128, -8'sd128, 1'b1, 1'b0);
    waitResult(5);
    checkResult("t4", ovfExpected, 2, 1);
    drainResult("t4");

    // Clear drops the in-flight (7,7) but keeps the pair accepted alongside it.
    applyStimulus(8'sd7, 8'sd7, 1'b0, 1'b0);
    applyStimulus(8'sd2, 8'sd3, 1'b1, 1'b1);
    waitResult(5);
    checkResult("t5", 6, 1, 0);
    drainResult("t5");

    // Reset mid-frame discards the partial frame entirely.
    applyStimulus(8'sd9, 8'sd9, 1'b0, 1'b0);
    applyStimulus(8'sd5, 8'sd5, 1'b0, 1'b0);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t6_no_stale_valid", int'(outValid), 0);
    end
    applyStimulus(-8'sd2, 8'sd4, 1'b1, 1'b0);
    waitResult(5);
    checkResult("t6", -8, 1, 0);
    drainResult("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
